// File: rtl/mesh_input_skewer.sv
`default_nettype none
// ============================================================================
// Module   : mesh_input_skewer
// Purpose  : Accepts one row vector per cycle and diagonally skews it onto the
//            mesh lanes, generating per-block propagate/shift control.
// Revision : 1.0 - initial release
// ============================================================================
module mesh_input_skewer #(
    parameter int DIM  = 8,
    parameter int A_W  = 8,
    parameter int B_W  = 19,
    parameter int SH_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_flush,
    input  logic                io_in_valid,
    output logic                io_in_ready,
    input  logic [DIM*A_W-1:0]  io_in_a,
    input  logic [DIM*B_W-1:0]  io_in_b,
    input  logic [DIM*B_W-1:0]  io_in_d,
    input  logic [SH_W-1:0]     io_in_shift,
    output logic [DIM*A_W-1:0]  io_out_a,
    output logic [DIM*B_W-1:0]  io_out_b,
    output logic [DIM*B_W-1:0]  io_out_d,
    output logic [DIM-1:0]      io_out_control_propagate,
    output logic [DIM*SH_W-1:0] io_out_control_shift,
    output logic [DIM-1:0]      io_out_valid,
    output logic                io_busy
);

    localparam int                c_ROW_W    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(DIM - 1);

    logic               r_reset_q;
    logic [c_ROW_W-1:0] r_row;
    logic               r_prop_q;
    logic [SH_W-1:0]    r_sh_q;

    logic               w_clear;
    logic               w_acc;
    logic [SH_W-1:0]    w_sh_eff;
    logic [DIM-1:0]     w_lane_busy;

    assign w_clear     = reset | io_flush;
    // Ready also masks the live reset so it is low from the very first reset cycle.
    assign io_in_ready = ~reset & ~r_reset_q & ~io_flush;
    assign w_acc       = io_in_valid & io_in_ready;
    assign w_sh_eff    = (r_row == '0) ? io_in_shift : r_sh_q;
    assign io_busy     = |w_lane_busy;

    always_ff @(posedge clock) begin
        r_reset_q <= reset;
    end

    // Block bookkeeping: row index, propagate polarity and latched shift.
    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_row    <= '0;
            r_prop_q <= 1'b0;
            r_sh_q   <= '0;
        end else if (w_acc) begin
            if (r_row == c_ROW_LAST) begin
                r_row    <= '0;
                r_prop_q <= ~r_prop_q;
            end else begin
                r_row <= r_row + c_ROW_W'(1);
            end
            if (r_row == '0) begin
                r_sh_q <= io_in_shift;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_lane
            localparam int c_DEPTH = gi + 1;

            logic [c_DEPTH-1:0] r_valid;
            logic [c_DEPTH-1:0] r_prop;
            logic [A_W-1:0]     r_a  [c_DEPTH];
            logic [B_W-1:0]     r_b  [c_DEPTH];
            logic [B_W-1:0]     r_d  [c_DEPTH];
            logic [SH_W-1:0]    r_sh [c_DEPTH];

            // Free-running shift register; bubbles carry zero data but live control.
            always_ff @(posedge clock) begin
                if (w_clear) begin
                    r_valid <= '0;
                    r_prop  <= '0;
                    for (int s = 0; s < c_DEPTH; s++) begin
                        r_a[s]  <= '0;
                        r_b[s]  <= '0;
                        r_d[s]  <= '0;
                        r_sh[s] <= '0;
                    end
                end else begin
                    r_valid[0] <= w_acc;
                    r_prop[0]  <= r_prop_q;
                    r_a[0]     <= w_acc ? io_in_a[gi*A_W +: A_W] : '0;
                    r_b[0]     <= w_acc ? io_in_b[gi*B_W +: B_W] : '0;
                    r_d[0]     <= w_acc ? io_in_d[gi*B_W +: B_W] : '0;
                    r_sh[0]    <= w_acc ? w_sh_eff : r_sh_q;
                    for (int s = 1; s < c_DEPTH; s++) begin
                        r_valid[s] <= r_valid[s-1];
                        r_prop[s]  <= r_prop[s-1];
                        r_a[s]     <= r_a[s-1];
                        r_b[s]     <= r_b[s-1];
                        r_d[s]     <= r_d[s-1];
                        r_sh[s]    <= r_sh[s-1];
                    end
                end
            end

            assign io_out_valid[gi]                     = r_valid[c_DEPTH-1];
            assign io_out_control_propagate[gi]         = r_prop[c_DEPTH-1];
            assign io_out_a[gi*A_W +: A_W]              = r_a[c_DEPTH-1];
            assign io_out_b[gi*B_W +: B_W]              = r_b[c_DEPTH-1];
            assign io_out_d[gi*B_W +: B_W]              = r_d[c_DEPTH-1];
            assign io_out_control_shift[gi*SH_W +: SH_W] = r_sh[c_DEPTH-1];
            assign w_lane_busy[gi]                      = |r_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mesh_input_skewer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesh_input_skewer
// Purpose  : Directed scoreboard bench for mesh_input_skewer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesh_input_skewer;

    localparam int DIM  = 8;
    localparam int A_W  = 8;
    localparam int B_W  = 19;
    localparam int SH_W = 4;

    logic                clock;
    logic                reset;
    logic                io_flush;
    logic                io_in_valid;
    logic                io_in_ready;
    logic [DIM*A_W-1:0]  io_in_a;
    logic [DIM*B_W-1:0]  io_in_b;
    logic [DIM*B_W-1:0]  io_in_d;
    logic [SH_W-1:0]     io_in_shift;
    logic [DIM*A_W-1:0]  io_out_a;
    logic [DIM*B_W-1:0]  io_out_b;
    logic [DIM*B_W-1:0]  io_out_d;
    logic [DIM-1:0]      io_out_control_propagate;
    logic [DIM*SH_W-1:0] io_out_control_shift;
    logic [DIM-1:0]      io_out_valid;
    logic                io_busy;

    mesh_input_skewer #(.DIM(DIM), .A_W(A_W), .B_W(B_W), .SH_W(SH_W)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_flush                 (io_flush),
        .io_in_valid              (io_in_valid),
        .io_in_ready              (io_in_ready),
        .io_in_a                  (io_in_a),
        .io_in_b                  (io_in_b),
        .io_in_d                  (io_in_d),
        .io_in_shift              (io_in_shift),
        .io_out_a                 (io_out_a),
        .io_out_b                 (io_out_b),
        .io_out_d                 (io_out_d),
        .io_out_control_propagate (io_out_control_propagate),
        .io_out_control_shift     (io_out_control_shift),
        .io_out_valid             (io_out_valid),
        .io_busy                  (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        int              lane;
        int              due;
        logic [A_W-1:0]  a;
        logic [B_W-1:0]  b;
        logic [B_W-1:0]  d;
        logic            prop;
        logic [SH_W-1:0] sh;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model of the block bookkeeping
    int              m_row  = 0;
    bit              m_prop = 1'b0;
    logic [SH_W-1:0] m_sh   = '0;
    bit              m_rstq = 1'b1;

    task automatic chk(input string tag, input int lane, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s lane %0d: observed %0h expected %0h", tag, lane, obs, exp_v);
        end
    endtask

    function automatic logic [DIM*A_W-1:0] row_a(input int tag);
        logic [DIM*A_W-1:0] r;
        for (int i = 0; i < DIM; i++) r[i*A_W +: A_W] = A_W'(tag * 8 + i + 1);
        return r;
    endfunction

    function automatic logic [DIM*B_W-1:0] row_bd(input int tag, input int base);
        logic [DIM*B_W-1:0] r;
        for (int i = 0; i < DIM; i++) r[i*B_W +: B_W] = B_W'(base + i + tag * 'h1000);
        return r;
    endfunction

    task automatic check_outputs();
        bit busy_exp;
        busy_exp = 1'b0;
        foreach (sb[k]) if (sb[k].due >= cyc) busy_exp = 1'b1;
        chk("busy", -1, 32'(io_busy), 32'(busy_exp));
        for (int i = 0; i < DIM; i++) begin
            int hit;
            hit = -1;
            foreach (sb[k]) if (sb[k].lane == i && sb[k].due == cyc) hit = k;
            if (hit >= 0) begin
                chk("valid", i, 32'(io_out_valid[i]), 32'd1);
                chk("a",     i, 32'(io_out_a[i*A_W +: A_W]), 32'(sb[hit].a));
                chk("b",     i, 32'(io_out_b[i*B_W +: B_W]), 32'(sb[hit].b));
                chk("d",     i, 32'(io_out_d[i*B_W +: B_W]), 32'(sb[hit].d));
                chk("prop",  i, 32'(io_out_control_propagate[i]), 32'(sb[hit].prop));
                chk("shift", i, 32'(io_out_control_shift[i*SH_W +: SH_W]), 32'(sb[hit].sh));
                sb.delete(hit);
            end else begin
                chk("idle_valid", i, 32'(io_out_valid[i]), 32'd0);
                chk("idle_a",     i, 32'(io_out_a[i*A_W +: A_W]), 32'd0);
                chk("idle_b",     i, 32'(io_out_b[i*B_W +: B_W]), 32'd0);
                chk("idle_d",     i, 32'(io_out_d[i*B_W +: B_W]), 32'd0);
            end
        end
    endtask

    // One clock cycle: drive inputs, predict acceptance, advance, check outputs.
    task automatic tick(input bit rst, input bit v, input bit fl, input logic [SH_W-1:0] sh, input int tag);
        bit              exp_ready;
        logic [SH_W-1:0] sh_eff;
        exp_t            e;
        reset       = rst;
        io_in_valid = v;
        io_flush    = fl;
        io_in_shift = sh;
        io_in_a     = row_a(tag);
        io_in_b     = row_bd(tag, 'h100);
        io_in_d     = row_bd(tag, 'h200);
        #1;
        exp_ready = !rst && !m_rstq && !fl;
        chk("ready", -1, 32'(io_in_ready), 32'(exp_ready));
        if (v && exp_ready) begin
            sh_eff = (m_row == 0) ? sh : m_sh;
            for (int i = 0; i < DIM; i++) begin
                e.lane = i;
                e.due  = cyc + 1 + i;
                e.a    = io_in_a[i*A_W +: A_W];
                e.b    = io_in_b[i*B_W +: B_W];
                e.d    = io_in_d[i*B_W +: B_W];
                e.prop = m_prop;
                e.sh   = sh_eff;
                sb.push_back(e);
            end
            if (m_row == 0) m_sh = sh;
            if (m_row == DIM - 1) begin
                m_row  = 0;
                m_prop = ~m_prop;
            end else begin
                m_row++;
            end
        end
        if (rst || fl) begin
            sb.delete();
            m_row  = 0;
            m_prop = 1'b0;
            m_sh   = '0;
        end
        m_rstq = rst;
        @(posedge clock);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 4'd0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with valid asserted: nothing accepted, control zero
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 1'b0, 4'd0, 0);
            chk("rst_prop",  -1, 32'(io_out_control_propagate), 32'd0);
            chk("rst_shift", -1, io_out_control_shift, 32'd0);
        end
        // Release cycle: ready still low, offered row dropped
        tick(1'b0, 1'b1, 1'b0, 4'd2, 0);

        // Single row skew
        tick(1'b0, 1'b1, 1'b0, 4'd0, 0);
        idle(10);
        tick(1'b0, 1'b0, 1'b1, 4'd0, 0);

        // Two consecutive blocks
        for (int k = 0; k < 16; k++)
            tick(1'b0, 1'b1, 1'b0, (k == 0) ? 4'd3 : (k == 8) ? 4'd5 : 4'd9, k + 1);
        idle(9);

        // Bubbles: rows on cycles 0, 2, 3, then five more to reach the wrap
        tick(1'b0, 1'b1, 1'b0, 4'd4, 20);
        tick(1'b0, 1'b0, 1'b0, 4'd0, 21);
        tick(1'b0, 1'b1, 1'b0, 4'd6, 22);
        tick(1'b0, 1'b1, 1'b0, 4'd6, 23);
        idle(9);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b0, 4'd1, 24 + k);
        idle(9);

        // Flush mid-flight together with valid
        tick(1'b0, 1'b1, 1'b0, 4'd2, 30);
        tick(1'b0, 1'b1, 1'b0, 4'd2, 31);
        tick(1'b0, 1'b1, 1'b0, 4'd2, 32);
        tick(1'b0, 1'b1, 1'b1, 4'd2, 33);
        tick(1'b0, 1'b1, 1'b0, 4'd7, 34);
        idle(9);
        tick(1'b0, 1'b0, 1'b1, 4'd0, 0);

        // Wrap with random idle gaps, then one row of the next block
        for (int k = 0; k < 9; k++) begin
            tick(1'b0, 1'b1, 1'b0, 4'(k + 10), 40 + k);
            idle($urandom_range(0, 3));
        end
        idle(10);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL drain: observed %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
